// File: rtl/sprite_arb_pkg.sv
// Sprite memory arbiter shared types.
// Owner encoding, CPU FSM states, defaults.
package sprite_arb_pkg;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_ACT_W        = 4;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_GPU
  } owner_e;

  typedef enum logic {
    C_IDLE,
    C_RESP
  } cpu_st_e;

endpackage

// File: rtl/sprite_mem_arbiter_if.sv
// CPU, renderer and sprite-memory bus bundle.
// slave = arbiter view, master = surroundings.
interface sprite_mem_arbiter_if
  import sprite_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ACT_W  = DEF_ACT_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                    cpu_re;
  logic                    cpu_we;
  logic [ADDR_W-1:0]       cpu_addr;
  logic [ACT_W-1:0]        cpu_action;
  logic [DATA_W-1:0]       cpu_wdata;
  logic                    cpu_stall;
  logic                    cpu_rvalid;
  logic [DATA_W-1:0]       cpu_rdata;

  logic                    gpu_req;
  logic [ADDR_W-1:0]       gpu_addr;
  logic [ACT_W-1:0]        gpu_action;
  logic                    gpu_gnt;
  logic                    gpu_rvalid;
  logic [DATA_W-1:0]       gpu_rdata;

  logic                    vblank;

  logic                    mem_en;
  logic                    mem_we;
  logic [ACT_W+ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr,
    input  cpu_action, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  gpu_req, gpu_addr, gpu_action,
    output gpu_gnt, gpu_rvalid, gpu_rdata,
    input  vblank,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr,
    output cpu_action, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output gpu_req, gpu_addr, gpu_action,
    input  gpu_gnt, gpu_rvalid, gpu_rdata,
    output vblank,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/sprite_arb_sel.sv
// Owner pick for the single memory port.
// CPU wins in vblank, on starvation or alone.
module sprite_arb_sel
  import sprite_arb_pkg::*;
(
  input  logic   cpu_pending_i,
  input  logic   gpu_req_i,
  input  logic   vblank_i,
  input  logic   starve_hit_i,
  output owner_e owner_o
);

  logic cpu_win;
  logic gpu_win;

  assign cpu_win = cpu_pending_i &&
                   (vblank_i || starve_hit_i || !gpu_req_i);
  assign gpu_win = gpu_req_i && !cpu_win;

  // one-hot owner decode
  always_comb begin
    owner_o = OWN_NONE;
    unique case (1'b1)
      cpu_win: owner_o = OWN_CPU;
      gpu_win: owner_o = OWN_GPU;
      default: owner_o = OWN_NONE;
    endcase
  end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Sprite memory arbiter: one access per cycle,
// CPU stalled by renderer at most STARVE_LIMIT.
module sprite_mem_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int ACT_W        = DEF_ACT_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
)(
  input logic clk,
  input logic rst_n,
  sprite_mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int MA_W  = ACT_W + ADDR_W;

  cpu_st_e           state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              gpu_rvalid_q;
  logic [MA_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;

  logic   cpu_req;
  logic   cpu_pending;
  logic   starve_hit;
  owner_e own_sel;
  owner_e own;

  assign cpu_req     = bus.cpu_re | bus.cpu_we;
  assign cpu_pending = cpu_req && (state_q == C_IDLE);
  assign starve_hit  = starve_q == CNT_W'(STARVE_LIMIT);

  sprite_arb_sel u_sel (
    .cpu_pending_i (cpu_pending),
    .gpu_req_i     (bus.gpu_req),
    .vblank_i      (bus.vblank),
    .starve_hit_i  (starve_hit),
    .owner_o       (own_sel)
  );

  // no grant can leak out while reset is held
  assign own = rst_n ? own_sel : OWN_NONE;

  // CPU handshake: stall until served, one response slot
  always_comb begin
    state_d        = state_q;
    bus.cpu_stall  = 1'b0;
    bus.cpu_rvalid = 1'b0;
    bus.cpu_rdata  = '0;
    unique case (state_q)
      C_IDLE: begin
        if (own == OWN_CPU && !bus.cpu_we) begin
          state_d       = C_RESP;
          bus.cpu_stall = 1'b1;
        end else if (cpu_req && own != OWN_CPU) begin
          bus.cpu_stall = 1'b1;
        end
      end
      C_RESP: begin
        state_d        = C_IDLE;
        bus.cpu_rvalid = 1'b1;
        bus.cpu_rdata  = bus.mem_rdata;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // count renderer wins while the CPU waits, saturating
  always_comb begin
    starve_d = starve_q;
    if (!cpu_pending || own == OWN_CPU) begin
      starve_d = '0;
    end else if (own == OWN_GPU && !starve_hit) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // memory address/data follow the owner, else hold
  always_comb begin
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    unique case (own)
      OWN_CPU: begin
        maddr_d = {bus.cpu_action, bus.cpu_addr};
        if (bus.cpu_we) mwdata_d = bus.cpu_wdata;
      end
      OWN_GPU: maddr_d = {bus.gpu_action, bus.gpu_addr};
      default: ;
    endcase
  end

  assign bus.mem_en     = own != OWN_NONE;
  assign bus.mem_we     = (own == OWN_CPU) && bus.cpu_we;
  assign bus.mem_addr   = maddr_d;
  assign bus.mem_wdata  = mwdata_d;
  assign bus.gpu_gnt    = own == OWN_GPU;
  assign bus.gpu_rvalid = gpu_rvalid_q;
  assign bus.gpu_rdata  = gpu_rvalid_q ? bus.mem_rdata : '0;

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= C_IDLE;
      starve_q     <= '0;
      gpu_rvalid_q <= 1'b0;
      maddr_q      <= '0;
      mwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      gpu_rvalid_q <= bus.gpu_gnt;
      maddr_q      <= maddr_d;
      mwdata_q     <= mwdata_d;
    end
  end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Bench for sprite_mem_arbiter: directed cases
// plus a short random mix, scoreboard on reads.
module tb_sprite_mem_arbiter;
  import sprite_arb_pkg::*;

  localparam int LIM = DEF_STARVE_LIMIT;

  logic clk = 1'b0;
  logic rst_n;
  logic preload;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [31:0] mem    [0:4095];
  logic [31:0] shadow [0:4095];
  logic [31:0] cpu_q [$];
  logic [31:0] gpu_q [$];

  sprite_mem_arbiter_if bus ();

  sprite_mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic bad(string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // sprite memory model: 1-cycle read, garbage otherwise
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= seed(i);
    end else begin
      if (bus.mem_en && bus.mem_we)
        mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= mem[bus.mem_addr];
    else
      bus.mem_rdata <= 32'hBAD0_0000 | 32'(cyc);
  end

  // monitor: pop expectations on every response
  always @(negedge clk) begin
    chk("excl_rvalid",
        64'(bus.cpu_rvalid & bus.gpu_rvalid), 64'd0);
    if (bus.cpu_rvalid) begin
      if (cpu_q.size() == 0) bad("cpu_unexpected");
      else chk("cpu_rdata", 64'(bus.cpu_rdata),
               64'(cpu_q.pop_front()));
    end
    if (bus.gpu_rvalid) begin
      if (gpu_q.size() == 0) bad("gpu_unexpected");
      else chk("gpu_rdata", 64'(bus.gpu_rdata),
               64'(gpu_q.pop_front()));
    end
    if (bus.gpu_gnt) begin
      gpu_q.push_back(shadow[{bus.gpu_action, bus.gpu_addr}]);
      chk("gpu_one_grant",
          {51'd0, bus.mem_we, bus.mem_addr},
          {51'd0, 1'b0, bus.gpu_action, bus.gpu_addr});
    end
  end

  initial begin
    int ng, cg, wc;
    bit busy, is_wr, done;
    rst_n = 1'b0;
    preload = 1'b1;
    bus.cpu_re = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_action = '0;
    bus.cpu_wdata = '0;
    bus.gpu_req = 1'b1;
    bus.gpu_addr = '0;
    bus.gpu_action = '0;
    bus.vblank = 1'b0;
    for (int i = 0; i < 4096; i++) shadow[i] = seed(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 64'(bus.cpu_stall), 64'd1);
    chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_gpu_gnt", 64'(bus.gpu_gnt), 64'd0);
    chk("rst_gpu_rvalid", 64'(bus.gpu_rvalid), 64'd0);
    cyc_start();
    bus.cpu_re = 1'b0;
    bus.gpu_req = 1'b0;
    preload = 1'b0;
    rst_n = 1'b1;
    repeat (2) cyc_start();

    // vblank write beats a pending renderer read
    bus.vblank = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 8'h05;
    bus.cpu_action = 4'h3;
    bus.cpu_wdata = 32'hDEAD_BEEF;
    bus.gpu_req = 1'b1;
    bus.gpu_addr = 8'h05;
    bus.gpu_action = 4'h3;
    @(negedge clk);
    chk("vb_mem_we", 64'(bus.mem_we), 64'd1);
    chk("vb_mem_en", 64'(bus.mem_en), 64'd1);
    chk("vb_mem_addr", 64'(bus.mem_addr), 64'h305);
    chk("vb_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
    chk("vb_stall", 64'(bus.cpu_stall), 64'd0);
    chk("vb_gpu_gnt", 64'(bus.gpu_gnt), 64'd0);
    shadow[12'h305] = 32'hDEAD_BEEF;
    cyc_start();
    bus.cpu_we = 1'b0;
    bus.vblank = 1'b0;
    @(negedge clk);
    chk("vb_gpu_next", 64'(bus.gpu_gnt), 64'd1);
    cyc_start();
    bus.gpu_req = 1'b0;
    cyc_start();

    // plain CPU read, 1-cycle latency
    bus.cpu_re = 1'b1;
    bus.cpu_addr = 8'h10;
    bus.cpu_action = 4'h0;
    cpu_q.push_back(shadow[12'h010]);
    @(negedge clk);
    chk("rd_stall_g", 64'(bus.cpu_stall), 64'd1);
    chk("rd_en_g", 64'(bus.mem_en), 64'd1);
    chk("rd_we_g", 64'(bus.mem_we), 64'd0);
    chk("rd_addr_g", 64'(bus.mem_addr), 64'h010);
    cyc_start();
    @(negedge clk);
    chk("rd_stall_g1", 64'(bus.cpu_stall), 64'd0);
    chk("rd_rvalid_g1", 64'(bus.cpu_rvalid), 64'd1);
    chk("rd_no_regrant", 64'(bus.mem_en), 64'd0);
    cyc_start();
    bus.cpu_re = 1'b0;
    @(negedge clk);
    chk("idle_en", 64'(bus.mem_en), 64'd0);
    chk("idle_addr_hold", 64'(bus.mem_addr), 64'h010);
    cyc_start();

    // starvation: 4 renderer grants then the CPU
    bus.cpu_re = 1'b1;
    bus.cpu_addr = 8'h05;
    bus.cpu_action = 4'h3;
    bus.gpu_req = 1'b1;
    bus.gpu_addr = 8'h21;
    bus.gpu_action = 4'h1;
    cpu_q.push_back(shadow[12'h305]);
    ng = 0;
    cg = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.gpu_gnt) ng++;
      else if (bus.mem_en) begin
        cg = k;
        break;
      end
      cyc_start();
    end
    chk("st_gpu_grants", 64'(ng), 64'd4);
    chk("st_cpu_slot", 64'(cg), 64'd5);
    cyc_start();
    @(negedge clk);
    chk("st_resp_gpu_gnt", 64'(bus.gpu_gnt), 64'd1);
    chk("st_cnt_clear", 64'(dut.starve_q), 64'd0);
    cyc_start();
    bus.cpu_re = 1'b0;
    bus.gpu_req = 1'b0;
    repeat (2) cyc_start();

    // read and write together: write only
    bus.cpu_re = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 8'h20;
    bus.cpu_action = 4'h2;
    bus.cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("rw_mem_we", 64'(bus.mem_we), 64'd1);
    chk("rw_stall", 64'(bus.cpu_stall), 64'd0);
    shadow[12'h220] = 32'h1234_5678;
    cyc_start();
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    @(negedge clk);
    chk("rw_no_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    cyc_start();
    bus.cpu_re = 1'b1;
    cpu_q.push_back(shadow[12'h220]);
    cyc_start();
    cyc_start();
    bus.cpu_re = 1'b0;
    cyc_start();

    // reset during the response cycle drops it
    bus.cpu_re = 1'b1;
    bus.cpu_addr = 8'h10;
    bus.cpu_action = 4'h0;
    @(negedge clk);
    chk("rr_grant_stall", 64'(bus.cpu_stall), 64'd1);
    cyc_start();
    rst_n = 1'b0;
    bus.cpu_re = 1'b0;
    @(negedge clk);
    chk("rr_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    chk("rr_state", 64'(dut.state_q), 64'(C_IDLE));
    cyc_start();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rr_after", 64'(bus.cpu_rvalid), 64'd0);
    end
    cyc_start();

    // random CPU/renderer mix with latency bound
    busy = 1'b0;
    wc = 0;
    is_wr = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      cyc_start();
      if (!busy) begin
        bus.cpu_re = 1'b0;
        bus.cpu_we = 1'b0;
      end
      if (!busy && $urandom_range(0, 1) == 1) begin
        busy = 1'b1;
        wc = 0;
        is_wr = $urandom_range(0, 2) == 0;
        bus.cpu_addr = 8'($urandom_range(0, 7));
        bus.cpu_action = 4'($urandom_range(0, 1));
        bus.cpu_wdata = $urandom;
        bus.cpu_we = is_wr;
        bus.cpu_re = !is_wr || $urandom_range(0, 3) == 0;
        if (!is_wr)
          cpu_q.push_back(
            shadow[{bus.cpu_action, bus.cpu_addr}]);
      end
      bus.gpu_req = $urandom_range(0, 3) != 0;
      bus.gpu_addr = 8'($urandom_range(0, 7));
      bus.gpu_action = 4'($urandom_range(0, 1));
      bus.vblank = $urandom_range(0, 7) == 0;
      @(negedge clk);
      if (busy) begin
        wc++;
        done = is_wr ? !bus.cpu_stall : bus.cpu_rvalid;
        if (done) begin
          if (is_wr)
            shadow[{bus.cpu_action, bus.cpu_addr}] =
              bus.cpu_wdata;
          chk("rnd_latency", 64'(wc <= LIM + 2), 64'd1);
          busy = 1'b0;
        end else if (wc > LIM + 2) begin
          bad("rnd_timeout");
          busy = 1'b0;
        end
      end
    end

    cyc_start();
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    bus.gpu_req = 1'b0;
    bus.vblank = 1'b0;
    repeat (4) @(negedge clk);
    chk("drain_cpu_q", 64'(cpu_q.size()), 64'd0);
    chk("drain_gpu_q", 64'(gpu_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
